// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scan controller with blanking gaps,
// double-buffered display data applied at frame boundaries, and leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        lz_suppress,
    output logic        load_ack,
    output logic [3:0]  an_n,
    output logic [3:0]  bcd,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    idx_r, idx_s;
    logic [15:0]   act_value_r, act_value_s, sh_value_r, sh_value_s;
    logic [3:0]    act_dp_r, act_dp_s, sh_dp_r, sh_dp_s;
    logic          act_lz_r, act_lz_s, sh_lz_r, sh_lz_s;
    logic          pending_r, pending_s;
    logic          boundary_s;
    logic [3:0]    an_n_s, bcd_s;
    logic          dp_n_s;

    // Digit i is blank when suppression is on and it and every digit to its left are zero.
    function automatic logic lz_blank(input logic [15:0] v, input logic lz, input logic [1:0] i);
        logic r;
        case (i)
            2'd3:    r = (v[15:12] == 4'h0);
            2'd2:    r = (v[15:8]  == 8'h00);
            2'd1:    r = (v[15:4]  == 12'h000);
            default: r = 1'b0;
        endcase
        return lz & r;
    endfunction

    // Next-state, data-buffer and output decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        act_value_s = act_value_r;
        act_dp_s    = act_dp_r;
        act_lz_s    = act_lz_r;
        sh_value_s  = sh_value_r;
        sh_dp_s     = sh_dp_r;
        sh_lz_s     = sh_lz_r;
        pending_s   = pending_r;
        boundary_s  = 1'b0;
        an_n_s      = 4'hF;
        bcd_s       = 4'hF;
        dp_n_s      = 1'b1;

        if (!en) begin
            state_s = S_IDLE;
            cnt_s   = {CW{1'b0}};
            idx_s   = 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_s   = {CW{1'b0}};
                    idx_s   = 2'd0;
                    state_s = S_BLANK;
                end
                S_BLANK: begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == BLANK_LAST) begin
                        state_s = S_DRIVE;
                    end else begin
                        state_s = S_BLANK;
                    end
                end
                S_DRIVE: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_s      = {CW{1'b0}};
                        idx_s      = idx_r + 2'd1;
                        state_s    = S_BLANK;
                        boundary_s = (idx_r == 2'd3);
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    cnt_s   = {CW{1'b0}};
                    idx_s   = 2'd0;
                end
            endcase
        end

        // A load in IDLE or on the frame edge skips the shadow copy entirely.
        if (load) begin
            if ((state_r == S_IDLE) || boundary_s) begin
                act_value_s = value;
                act_dp_s    = dp;
                act_lz_s    = lz_suppress;
                pending_s   = 1'b0;
            end else begin
                sh_value_s = value;
                sh_dp_s    = dp;
                sh_lz_s    = lz_suppress;
                pending_s  = 1'b1;
            end
        end else if (boundary_s && pending_r) begin
            act_value_s = sh_value_r;
            act_dp_s    = sh_dp_r;
            act_lz_s    = sh_lz_r;
            pending_s   = 1'b0;
        end else begin
            pending_s = pending_r;
        end

        if (state_s == S_DRIVE) begin
            an_n_s = ~(4'b0001 << idx_s);
            dp_n_s = ~act_dp_s[idx_s];
            if (lz_blank(act_value_s, act_lz_s, idx_s)) begin
                bcd_s = 4'hF;
            end else begin
                bcd_s = act_value_s[{idx_s, 2'b00} +: 4];
            end
        end else begin
            an_n_s = 4'hF;
            bcd_s  = 4'hF;
            dp_n_s = 1'b1;
        end
    end

    // State, buffers and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= 2'd0;
            act_value_r <= 16'h0000;
            act_dp_r    <= 4'h0;
            act_lz_r    <= 1'b0;
            sh_value_r  <= 16'h0000;
            sh_dp_r     <= 4'h0;
            sh_lz_r     <= 1'b0;
            pending_r   <= 1'b0;
            an_n        <= 4'hF;
            bcd         <= 4'hF;
            dp_n        <= 1'b1;
            load_ack    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            act_value_r <= act_value_s;
            act_dp_r    <= act_dp_s;
            act_lz_r    <= act_lz_s;
            sh_value_r  <= sh_value_s;
            sh_dp_r     <= sh_dp_s;
            sh_lz_r     <= sh_lz_s;
            pending_r   <= pending_s;
            an_n        <= an_n_s;
            bcd         <= bcd_s;
            dp_n        <= dp_n_s;
            load_ack    <= load;
            frame_done  <= boundary_s;
        end
    end

endmodule
